work_dispatcher: RTL and testbench
==================================

WORK_DISPATCHER -- requirements
Module: work_dispatcher

Interface
REQ-001 SHALL have parameter START_PULSE, default 4: cycles start_mining is held high per job (>=3, spans the miner's 2-flop synchroniser).
REQ-002 SHALL have parameter RX_GAP, default 24'd1000000: idle cycles after which a partial work frame is discarded.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  work byte from host byte link.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-007 SHALL have port midstate  output  256  job midstate to miner core.
REQ-008 SHALL have port data2  output  96  job tail (merkle end, ntime, nbits) to miner core.
REQ-009 SHALL have port start_mining  output  1  job start level pulse to miner core.
REQ-010 SHALL have port miner_busy  input  1  miner core working flag.
REQ-011 SHALL have port got_ticket  input  1  miner core sticky "nonce found" flag.
REQ-012 SHALL have port golden_nonce  input  32  found nonce, valid while got_ticket=1.
REQ-013 SHALL have port tx_data  output  8  result byte to host link.
REQ-014 SHALL have port tx_valid  output  1  tx_data valid; held until accepted.
REQ-015 SHALL have port tx_ready  input  1  host link accepts byte when tx_valid&&tx_ready.

Function
REQ-016 SHALL assemble 64-byte work frames from rx_valid bytes into a shadow buffer using a 6-bit byte counter, independent of the dispatch state.
REQ-017 SHALL map frame bytes 0..31 to midstate, first byte into [255:248], byte 31 into [7:0]; bytes 32..51 SHALL be discarded; bytes 52..63 SHALL map to data2, byte 52 into [95:88].
REQ-018 SHALL keep midstate/data2 outputs stable except on the single cycle a completed frame is dispatched (shadow copied to outputs).
REQ-019 SHALL run a gap counter that clears on every rx_valid; when counter reaches RX_GAP with byte counter nonzero, byte counter SHALL return to 0 (partial frame dropped).
REQ-020 SHALL implement states IDLE, START, ARM, MINE, TX.
REQ-021 IDLE: on frame completion -> copy shadow, START.
REQ-022 START: start_mining=1 for exactly START_PULSE cycles, then ARM.
REQ-023 ARM: wait miner_busy=1 -> MINE; got_ticket ignored in ARM (may hold stale value from previous job).
REQ-024 MINE: got_ticket rising edge (registered previous value 0, current 1) -> capture golden_nonce into 32-bit tx shift register, TX; miner_busy=0 with no ticket -> IDLE, nothing sent.
REQ-025 TX: send 4 bytes, golden_nonce[31:24] first; tx_valid held with constant tx_data until tx_ready; after 4th handshake -> IDLE.
REQ-026 Frame completion in START, ARM or MINE SHALL abort current job: copy shadow, restart START (START_PULSE counter reloaded).
REQ-027 Frame completion in TX SHALL set a pending flag; TX SHALL finish all 4 bytes, then go directly to START with the pending frame, clearing the flag.
REQ-028 Frame completion and rx_valid on the same cycle as a ticket edge: ticket SHALL be discarded, new job wins.
REQ-029 Byte counter SHALL wrap 63->0 on the completing byte.

Reset
REQ-030 On rst=1, asynchronously: state IDLE, byte counter 0, gap counter 0, pending 0, midstate 0, data2 0, start_mining 0, tx_valid 0, tx_data 0, tx shift 0.
REQ-031 Reset mid-frame or mid-TX SHALL drop all partial data; no byte SHALL be emitted after rst deasserts until a new ticket.

Verification
REQ-032 64 bytes 0x00..0x3F -> midstate=256'h000102..1F, data2=96'h3435..3F, start_mining high exactly 4 cycles.
REQ-033 Frame, model raises miner_busy then got_ticket with golden_nonce=32'h1234ABCD, tx_ready=1 -> bytes 12,34,AB,CD then IDLE.
REQ-034 tx_ready held low 10 cycles per byte -> tx_valid stays high, tx_data unchanged until each acceptance.
REQ-035 30 bytes, then RX_GAP idle cycles, then 64 new bytes -> outputs reflect only the 64 new bytes, one dispatch.
REQ-036 Stale got_ticket=1 during START/ARM -> no TX; miner_busy falls without ticket -> IDLE, tx_valid never asserted.
REQ-037 Second frame completed during TX -> all 4 result bytes sent, then START with second frame's midstate.

Source files
------------

// File: rtl/work_dispatcher.sv
// rtl/work_dispatcher.sv - assembles host work frames, dispatches jobs to the miner core, returns found nonces
module work_dispatcher #(
  parameter int          START_PULSE = 4,
  parameter logic [23:0] RX_GAP      = 24'd1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [255:0] midstate,
  output logic [95:0]  data2,
  output logic         start_mining,
  input  logic         miner_busy,
  input  logic         got_ticket,
  input  logic [31:0]  golden_nonce,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_MINE  = 3'd3;
  localparam logic [2:0] S_TX    = 3'd4;

  localparam logic [7:0] PULSE_LAST = 8'(START_PULSE - 1);

  logic [2:0]   state;
  logic [5:0]   byte_cnt;
  logic [23:0]  gap_cnt;
  logic [255:0] shadow_mid, mid_next;
  logic [95:0]  shadow_d2, d2_next;
  logic         frame_done, pending, ticket_q, ticket_edge;
  logic         tx_last_hs, launch;
  logic [7:0]   pulse_cnt;
  logic [31:0]  tx_shift;
  logic [1:0]   tx_cnt;

  // Shadow contents including the byte arriving this cycle, so a completing
  // byte can be dispatched on the same edge it is received.
  always_comb begin
    mid_next = shadow_mid;
    d2_next  = shadow_d2;
    if (rx_valid) begin
      if (byte_cnt < 6'd32)
        mid_next[{~byte_cnt[4:0], 3'b000} +: 8] = rx_data;
      else if (byte_cnt >= 6'd52)
        d2_next[{~byte_cnt, 3'b000} +: 8] = rx_data;
    end
  end

  assign frame_done  = rx_valid && (byte_cnt == 6'd63);
  assign ticket_edge = got_ticket && !ticket_q;
  assign tx_last_hs  = tx_valid && tx_ready && (tx_cnt == 2'd3);
  assign launch      = (state == S_TX) ? (tx_last_hs && (pending || frame_done)) : frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      shadow_mid <= '0;
      shadow_d2  <= '0;
    end else if (rx_valid) begin
      byte_cnt   <= byte_cnt + 6'd1;
      gap_cnt    <= '0;
      shadow_mid <= mid_next;
      shadow_d2  <= d2_next;
    end else if (gap_cnt != RX_GAP) begin
      gap_cnt <= gap_cnt + 24'd1;
    end else if (byte_cnt != 6'd0) begin
      byte_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pending      <= 1'b0;
      ticket_q     <= 1'b0;
      midstate     <= '0;
      data2        <= '0;
      start_mining <= 1'b0;
      pulse_cnt    <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
    end else begin
      ticket_q <= got_ticket;
      if (launch) begin
        midstate     <= mid_next;
        data2        <= d2_next;
        state        <= S_START;
        start_mining <= 1'b1;
        pulse_cnt    <= PULSE_LAST;
        pending      <= 1'b0;
        tx_valid     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_START: begin
            if (pulse_cnt == 8'd0) begin
              start_mining <= 1'b0;
              state        <= S_ARM;
            end else begin
              pulse_cnt <= pulse_cnt - 8'd1;
            end
          end
          // A ticket left high from the previous job is not an edge here.
          S_ARM: if (miner_busy) state <= S_MINE;
          S_MINE: begin
            if (ticket_edge) begin
              tx_shift <= golden_nonce;
              tx_data  <= golden_nonce[31:24];
              tx_valid <= 1'b1;
              tx_cnt   <= 2'd0;
              state    <= S_TX;
            end else if (!miner_busy) begin
              state <= S_IDLE;
            end
          end
          S_TX: begin
            if (frame_done) pending <= 1'b1;
            if (tx_valid && tx_ready) begin
              if (tx_cnt == 2'd3) begin
                tx_valid <= 1'b0;
                state    <= S_IDLE;
              end else begin
                tx_shift <= {tx_shift[23:0], 8'h00};
                tx_data  <= tx_shift[23:16];
                tx_cnt   <= tx_cnt + 2'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_work_dispatcher.sv
// tb/tb_work_dispatcher.sv - scoreboard bench for work_dispatcher
module tb_work_dispatcher;

  localparam logic [23:0] GAP = 24'd40;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [255:0] midstate;
  logic [95:0]  data2;
  logic         start_mining;
  logic         miner_busy;
  logic         got_ticket;
  logic [31:0]  golden_nonce;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;

  work_dispatcher #(.START_PULSE(4), .RX_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .midstate(midstate), .data2(data2), .start_mining(start_mining),
    .miner_busy(miner_busy), .got_ticket(got_ticket), .golden_nonce(golden_nonce),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] exp_mid_q[$];
  logic [95:0]  exp_d2_q[$];
  logic [7:0]   exp_tx_q[$];
  logic [7:0]   frame_buf[64];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_inc(input logic [7:0] base);
    for (int i = 0; i < 64; i++) frame_buf[i] = base + 8'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input int n, input bit tick_last);
    logic [255:0] m;
    logic [95:0]  d;
    for (int i = 0; i < n; i++) begin
      rx_data  = frame_buf[i];
      rx_valid = 1'b1;
      if (tick_last && i == n - 1) got_ticket = 1'b1;
      cyc(1);
    end
    rx_valid = 1'b0;
    if (n == 64) begin
      m = '0;
      d = '0;
      for (int i = 0; i < 32; i++) m = {m[247:0], frame_buf[i]};
      for (int i = 52; i < 64; i++) d = {d[87:0], frame_buf[i]};
      exp_mid_q.push_back(m);
      exp_d2_q.push_back(d);
    end
  endtask

  task automatic ticket(input logic [31:0] nonce);
    miner_busy = 1'b1;
    cyc(3);
    golden_nonce = nonce;
    got_ticket   = 1'b1;
    for (int i = 3; i >= 0; i--) exp_tx_q.push_back(nonce[i*8 +: 8]);
  endtask

  task automatic wait_tx_done(input int budget);
    int k = 0;
    while (exp_tx_q.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    if (exp_tx_q.size() != 0) begin
      check("tx_timeout", exp_tx_q.size(), 0);
      exp_tx_q.delete();
    end
  endtask

  task automatic wait_tx_valid(input int budget);
    int k = 0;
    while (!tx_valid && k < budget) begin
      cyc(1);
      k++;
    end
    if (!tx_valid) check("tx_valid_timeout", tx_valid, 1);
  endtask

  // Scoreboard monitor: dispatches and result bytes, sampled on the falling edge.
  logic       sm_q = 1'b0;
  int         pulse_len = 0;
  logic [7:0] hold_data;
  bit         hold_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sm_q       = 1'b0;
      hold_valid = 1'b0;
    end else begin
      if (start_mining && !sm_q) begin
        if (exp_mid_q.size() == 0) check("disp_unexpected", 1, 0);
        else begin
          check("disp_midstate", midstate, exp_mid_q.pop_front());
          check("disp_data2", data2, exp_d2_q.pop_front());
          check("disp_after_tx", exp_tx_q.size(), 0);
        end
        pulse_len = 0;
      end
      if (start_mining) pulse_len++;
      if (!start_mining && sm_q) check("start_pulse_len", pulse_len, 4);
      sm_q = start_mining;

      if (tx_valid) begin
        if (exp_tx_q.size() == 0) check("tx_unexpected", tx_valid, 0);
        else begin
          if (hold_valid) check("tx_hold_stable", tx_data, hold_data);
          if (tx_ready) begin
            check("tx_byte", tx_data, exp_tx_q.pop_front());
            hold_valid = 1'b0;
          end else begin
            hold_valid = 1'b1;
            hold_data  = tx_data;
          end
        end
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; miner_busy = 1'b0;
    got_ticket = 1'b0; golden_nonce = '0; tx_ready = 1'b0;
    cyc(3);
    check("rst_midstate", midstate, 0);
    check("rst_data2", data2, 0);
    check("rst_start", start_mining, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b0;
    cyc(2);

    // Incrementing frame, then a ticket with an always-ready link
    fill_inc(8'h00);
    send_frame(64, 1'b0);
    cyc(6);
    check("inc_midstate", midstate, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check("inc_data2", data2, 96'h3435363738393a3b3c3d3e3f);
    tx_ready = 1'b1;
    ticket(32'h1234ABCD);
    wait_tx_done(50);
    cyc(2);
    miner_busy = 1'b0; got_ticket = 1'b0;
    cyc(2);

    // Backpressured link: ready only once per 10 idle cycles
    tx_ready = 1'b0;
    fill_rand();
    send_frame(64, 1'b0);
    cyc(6);
    ticket($urandom());
    for (int b = 0; b < 4; b++) begin
      wait_tx_valid(20);
      cyc(10);
      tx_ready = 1'b1;
      cyc(1);
      tx_ready = 1'b0;
    end
    wait_tx_done(20);
    miner_busy = 1'b0; got_ticket = 1'b0;
    cyc(3);

    // Partial frame dropped after an idle gap
    fill_rand();
    send_frame(30, 1'b0);
    cyc(int'(GAP) + 3);
    fill_rand();
    send_frame(64, 1'b0);
    cyc(8);

    // Stale ticket through START/ARM, miner quits without a result
    tx_ready   = 1'b1;
    got_ticket = 1'b1;
    fill_rand();
    send_frame(64, 1'b0);
    cyc(6);
    miner_busy = 1'b1;
    cyc(5);
    miner_busy = 1'b0;
    cyc(5);
    got_ticket = 1'b0;
    cyc(2);

    // Second frame completes while the result is still being sent
    tx_ready = 1'b0;
    fill_inc(8'h80);
    send_frame(64, 1'b0);
    cyc(6);
    ticket(32'hCAFE_0042);
    cyc(3);
    fill_rand();
    send_frame(64, 1'b0);
    cyc(5);
    tx_ready = 1'b1;
    wait_tx_done(50);
    cyc(8);

    // New frame completes on the same cycle as a ticket edge: job wins
    miner_busy = 1'b1; got_ticket = 1'b0;
    cyc(3);
    golden_nonce = 32'hDEAD_BEEF;
    fill_rand();
    send_frame(64, 1'b1);
    cyc(8);
    miner_busy = 1'b0;
    cyc(3);
    got_ticket = 1'b0;
    cyc(2);

    // Reset in the middle of a result and a partial frame
    tx_ready = 1'b0;
    fill_rand();
    send_frame(64, 1'b0);
    cyc(6);
    ticket(32'h0BAD_F00D);
    wait_tx_valid(20);
    fill_rand();
    send_frame(20, 1'b0);
    rst = 1'b1;
    cyc(2);
    check("mid_rst_midstate", midstate, 0);
    check("mid_rst_data2", data2, 0);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_tx_data", tx_data, 0);
    exp_tx_q.delete();
    miner_busy = 1'b0; got_ticket = 1'b0;
    rst = 1'b0;
    tx_ready = 1'b1;
    cyc(5);
    check("no_tx_after_rst", tx_valid, 0);
    fill_rand();
    send_frame(64, 1'b0);
    cyc(8);

    check("dispatch_q_empty", exp_mid_q.size(), 0);
    check("tx_q_empty", exp_tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
